// File: rtl/gpca_op_sequencer.sv
// Feeds one MUL/SQR/SQRT/DIV at a time into the combinational gpca array; response SETTLE_CYCLES edges after accept
// (divide-by-zero answers on the accept edge). in_ready only in IDLE; the response is held in DONE until out_ready.
module gpca_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [8:0]  DIV0_F        = 9'h1FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [17:0] in_a,
    input  logic [8:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_f,
    output logic [18:0] out_s,
    output logic        out_err,
    output logic        busy,
    output logic        gpca_x,
    output logic [8:0]  gpca_p,
    output logic [17:0] gpca_a,
    output logic [18:0] gpca_b,
    output logic [18:0] gpca_c,
    input  logic [8:0]  gpca_f,
    input  logic [18:0] gpca_s
);

    localparam logic [1:0]  OP_MUL  = 2'b00;
    localparam logic [1:0]  OP_SQR  = 2'b01;
    localparam logic [1:0]  OP_SQRT = 2'b10;
    localparam logic [1:0]  OP_DIV  = 2'b11;
    localparam logic [18:0] ONE     = 19'b0011_1111_1111_1111_111;
    localparam logic [18:0] TWO     = 19'b0100_0000_0000_0000_000;
    localparam logic [7:0]  CNT_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        out_valid_q, out_valid_d;
    logic        out_err_q, out_err_d;
    logic [8:0]  out_f_q, out_f_d;
    logic [18:0] out_s_q, out_s_d;
    logic        gx_q, gx_d;
    logic [8:0]  gp_q, gp_d;
    logic [17:0] ga_q, ga_d;
    logic [18:0] gb_q, gb_d;
    logic [18:0] gc_q, gc_d;

    logic        fmt_x;
    logic [8:0]  fmt_p;
    logic [17:0] fmt_a;
    logic [18:0] fmt_b;
    logic [18:0] fmt_c;
    logic        div_by_zero;

    // Control-vector encoding of the requested operation for the array.
    always_comb begin
        fmt_x = 1'b0;
        fmt_p = '0;
        fmt_a = '0;
        fmt_b = '0;
        fmt_c = '0;
        case (in_op)
            OP_MUL: begin
                fmt_p = in_b;
                fmt_b = {in_a[8:0], 10'b0};
                fmt_c = {in_a[8:0], 10'b0};
            end
            OP_SQR: begin
                fmt_p = in_b;
                fmt_b = ONE;
                fmt_c = TWO;
            end
            OP_SQRT: begin
                fmt_x = 1'b1;
                fmt_a = in_a;
                fmt_b = ONE;
                fmt_c = TWO;
            end
            default: begin
                fmt_x = 1'b1;
                fmt_a = in_a;
                fmt_b = {in_b, 10'b0};
                fmt_c = {in_b, 10'b0};
            end
        endcase
    end

    assign div_by_zero = (in_op == OP_DIV) && (in_b == 9'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_f_d     = out_f_q;
        out_s_d     = out_s_q;
        gx_d        = gx_q;
        gp_d        = gp_q;
        ga_d        = ga_q;
        gb_d        = gb_q;
        gc_d        = gc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (div_by_zero) begin
                        // Array never runs: answer immediately and leave its inputs quiet.
                        state_d     = DONE;
                        out_f_d     = DIV0_F;
                        out_s_d     = '0;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                        gx_d    = fmt_x;
                        gp_d    = fmt_p;
                        ga_d    = fmt_a;
                        gb_d    = fmt_b;
                        gc_d    = fmt_c;
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    out_f_d     = gpca_f;
                    out_s_d     = gpca_s;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    gx_d        = 1'b0;
                    gp_d        = '0;
                    ga_d        = '0;
                    gb_d        = '0;
                    gc_d        = '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_err_d   = 1'b0;
                gx_d        = 1'b0;
                gp_d        = '0;
                ga_d        = '0;
                gb_d        = '0;
                gc_d        = '0;
            end
        endcase
        // Handshake flags are registered so they never glitch on a state change.
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_f_q     <= '0;
            out_s_q     <= '0;
            gx_q        <= 1'b0;
            gp_q        <= '0;
            ga_q        <= '0;
            gb_q        <= '0;
            gc_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_f_q     <= out_f_d;
            out_s_q     <= out_s_d;
            gx_q        <= gx_d;
            gp_q        <= gp_d;
            ga_q        <= ga_d;
            gb_q        <= gb_d;
            gc_q        <= gc_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign out_f     = out_f_q;
    assign out_s     = out_s_q;
    assign gpca_x    = gx_q;
    assign gpca_p    = gp_q;
    assign gpca_a    = ga_q;
    assign gpca_b    = gb_q;
    assign gpca_c    = gc_q;

endmodule

// File: tb/tb_gpca_op_sequencer.sv
// Bench for gpca_op_sequencer: behavioural gpca stub decoding the control vectors, vector table,
// directed corner sequences and randomized ops checked against an operation-level model.
module tb_gpca_op_sequencer;

    localparam int N = 8;
    localparam logic [18:0] ONE = 19'h1FFFF;
    localparam logic [18:0] TWO = 19'h20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_op = '0;
    logic [17:0] in_a = '0;
    logic [8:0]  in_b = '0;
    logic        in_ready, out_valid, out_err, busy, gpca_x;
    logic [8:0]  out_f, gpca_p, gpca_f;
    logic [18:0] out_s, gpca_b, gpca_c, gpca_s;
    logic [17:0] gpca_a;

    logic        ovr_en = 1'b0;
    logic [8:0]  ovr_f = '0;
    logic [18:0] ovr_s = '0;

    int n_vec = 0;
    int n_bad = 0;

    gpca_op_sequencer #(.SETTLE_CYCLES(N), .DIV0_F(9'h1FF)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_s(out_s), .out_err(out_err),
        .busy(busy),
        .gpca_x(gpca_x), .gpca_p(gpca_p), .gpca_a(gpca_a), .gpca_b(gpca_b), .gpca_c(gpca_c),
        .gpca_f(gpca_f), .gpca_s(gpca_s)
    );

    always #5 clk = ~clk;

    function automatic int unsigned isqrt(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Array stand-in: recognises the control-vector patterns and computes what the array would return.
    always_comb begin
        int unsigned pv, av, dv, q;
        pv = gpca_p;
        av = gpca_a;
        dv = gpca_b[18:10];
        q  = 0;
        gpca_f = '0;
        gpca_s = '0;
        if (ovr_en) begin
            gpca_f = ovr_f;
            gpca_s = ovr_s;
        end else if (!gpca_x) begin
            if (gpca_b == ONE && gpca_c == TWO) gpca_s = 19'(pv * pv);
            else if (gpca_b == gpca_c)          gpca_s = 19'(pv * dv);
            else                                gpca_s = '1;
        end else begin
            if (gpca_b == ONE && gpca_c == TWO) begin
                q = isqrt(av);
                gpca_f = 9'(q);
                gpca_s = 19'(av - q * q);
            end else if (gpca_b == gpca_c && dv != 0) begin
                gpca_f = 9'(av / dv);
                gpca_s = 19'(av % dv);
            end else begin
                gpca_f = '1;
                gpca_s = '1;
            end
        end
    end

    typedef struct {
        logic [8:0]  f;
        logic [18:0] s;
        logic        err;
        int          edges;
    } resp_t;

    // Operation-level expectation straight from the arithmetic definition of each op.
    function automatic resp_t model(input logic [1:0] op, input logic [17:0] a, input logic [8:0] b);
        resp_t r;
        int unsigned av, bv, q;
        av = a;
        bv = b;
        r.f = '0; r.s = '0; r.err = 1'b0; r.edges = N;
        case (op)
            2'd0: r.s = 19'((av % 512) * bv);
            2'd1: r.s = 19'(bv * bv);
            2'd2: begin
                q = $rtoi($sqrt(real'(av)));
                r.f = 9'(q);
                r.s = 19'(av - q * q);
            end
            default: begin
                if (bv == 0) begin
                    r.f = 9'h1FF; r.err = 1'b1; r.edges = 0;
                end else begin
                    r.f = 9'(av / bv);
                    r.s = 19'(av % bv);
                end
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [17:0] a, input logic [8:0] b);
        int g;
        g = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("accept_timeout", 96'(in_ready), 96'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_op = 2'($urandom);
        in_a  = 18'($urandom);
        in_b  = 9'($urandom);
    endtask

    task automatic wait_resp(output int e);
        e = 0;
        while (!out_valid && e < 300) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic do_op(input string nm, input logic [1:0] op, input logic [17:0] a, input logic [8:0] b,
                         input logic [8:0] ef, input logic [18:0] es, input logic ee, input int eedges,
                         input int hold, input bit early);
        int e;
        logic [8:0]  f0;
        logic [18:0] s0;
        logic        stable;
        send(op, a, b);
        if (early) out_ready = 1'b1;
        wait_resp(e);
        chk({nm, "/latency"}, 96'(e), 96'(eedges));
        chk({nm, "/gpca_quiet"}, 96'({gpca_x, gpca_p, gpca_a, gpca_b, gpca_c} != 0), 96'd0);
        f0 = out_f; s0 = out_s; stable = 1'b1;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!out_valid || out_f !== f0 || out_s !== s0 || in_ready) stable = 1'b0;
            end
            if (hold > 0) chk({nm, "/hold_stable"}, 96'(stable), 96'd1);
        end
        chk({nm, "/out_f"}, 96'(out_f), 96'(ef));
        chk({nm, "/out_s"}, 96'(out_s), 96'(es));
        chk({nm, "/out_err"}, 96'(out_err), 96'(ee));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "/after_hs"}, 96'({out_valid, out_err, in_ready, busy}), 96'(4'b0010));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [17:0] a;
        logic [8:0]  b;
        logic [8:0]  f;
        logic [18:0] s;
        logic        err;
        int          edges;
    } vec_t;

    vec_t vt[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        bit seen;
        resp_t r;
        logic [1:0]  rop;
        logic [17:0] ra;
        logic [8:0]  rb;

        vt[0] = '{2'd0, 18'd7,       9'd5,   9'd0,   19'd35,      1'b0, N};
        vt[1] = '{2'd0, 18'h3FFFF,   9'h1FF, 9'd0,   19'h3FC01,   1'b0, N};
        vt[2] = '{2'd1, 18'd123,     9'd5,   9'd0,   19'd25,      1'b0, N};
        vt[3] = '{2'd1, 18'd0,       9'd0,   9'd0,   19'd0,       1'b0, N};
        vt[4] = '{2'd2, 18'd25,      9'd77,  9'd5,   19'd0,       1'b0, N};
        vt[5] = '{2'd2, 18'h3FFFF,   9'd0,   9'h1FF, 19'd1022,    1'b0, N};
        vt[6] = '{2'd3, 18'd35,      9'd5,   9'd7,   19'd0,       1'b0, N};
        vt[7] = '{2'd3, 18'd100,     9'd7,   9'd14,  19'd2,       1'b0, N};
        vt[8] = '{2'd3, 18'd35,      9'd0,   9'h1FF, 19'd0,       1'b1, 0};
        vt[9] = '{2'd3, 18'd511,     9'd1,   9'h1FF, 19'd0,       1'b0, N};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset/handshake", 96'({in_ready, out_valid, out_err, busy}), 96'(4'b1000));
        chk("reset/out_data", 96'({out_f, out_s}), 96'd0);
        chk("reset/gpca", 96'({gpca_x, gpca_p, gpca_a, gpca_b, gpca_c}), 96'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7*5 with stub S=0x12345: formatting held through SETTLE, response after exactly N edges.
        ovr_en = 1'b1; ovr_f = 9'd0; ovr_s = 19'h12345;
        send(2'd0, 18'd7, 9'd5);
        chk("mul/fmt_early", {gpca_x, gpca_p, gpca_a, gpca_b, gpca_c},
            {1'b0, 9'd5, 18'd0, 19'b0000_0011_1000_0000_000, 19'b0000_0011_1000_0000_000});
        chk("mul/busy", 96'({busy, in_ready}), 96'(2'b10));
        repeat (3) @(negedge clk);
        chk("mul/fmt_late", {gpca_x, gpca_p, gpca_a, gpca_b, gpca_c},
            {1'b0, 9'd5, 18'd0, 19'h01C00, 19'h01C00});
        wait_resp(e);
        chk("mul/latency", 96'(e + 3), 96'(N));
        chk("mul/out_s", 96'(out_s), 96'h12345);
        // Stub output changes while response is held: captured data must not follow.
        ovr_f = 9'h0AA; ovr_s = 19'h55555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold/data", 96'({out_valid, in_ready, out_s}), {77'd0, 1'b1, 1'b0, 19'h12345});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ovr_en = 1'b0;
        chk("hold/in_ready_after", 96'({in_ready, out_valid}), 96'(2'b10));

        // SQRT 25 formatting.
        send(2'd2, 18'd25, 9'd300);
        chk("sqrt/fmt", {gpca_x, gpca_p, gpca_a, gpca_b, gpca_c}, {1'b1, 9'd0, 18'd25, ONE, TWO});
        wait_resp(e);
        chk("sqrt/result", 96'({out_f, out_err, e}), 96'({9'd5, 1'b0, 32'(N)}));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Divide-by-zero: answer on the accept edge, array inputs untouched.
        send(2'd3, 18'd35, 9'd0);
        chk("div0/resp", 96'({out_valid, out_err, out_f, out_s}), 96'({1'b1, 1'b1, 9'h1FF, 19'd0}));
        chk("div0/gpca", 96'({gpca_x, gpca_p, gpca_a, gpca_b, gpca_c}), 96'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of SETTLE aborts the op with no response.
        send(2'd3, 18'd35, 9'd5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort/handshake", 96'({in_ready, out_valid, busy}), 96'(3'b100));
        chk("abort/gpca", 96'({gpca_x, gpca_p, gpca_a, gpca_b, gpca_c}), 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort/no_response", 96'(seen), 96'd0);
        do_op("abort/next_mul", 2'd0, 18'd9, 9'd11, 9'd0, 19'd99, 1'b0, N, 0, 1'b0);

        // Back-to-back with in_valid held and out_ready high: one idle cycle between responses.
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd1; in_a = 18'd0; in_b = 9'd5;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 0) begin in_op = 2'd3; in_a = 18'd35; in_b = 9'd5; end
            if (k == 10) in_valid = 1'b0;
            chk($sformatf("b2b/k%0d", k), 96'({out_valid, in_ready}),
                96'({(k == 8 || k == 18), (k == 9 || k >= 19)}));
            if (k == 8)  chk("b2b/sqr_s", 96'(out_s), 96'd25);
            if (k == 18) chk("b2b/div_fs", 96'({out_f, out_s}), 96'({9'd7, 19'd0}));
        end
        out_ready = 1'b0;

        // Vector table.
        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].f, vt[i].s, vt[i].err,
                  vt[i].edges, i % 3, (i % 4) == 3);

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom);
            ra  = 18'($urandom);
            rb  = 9'($urandom);
            if (rop == 2'd3 && $urandom_range(0, 3) == 0) rb = 9'd0;
            if (rop == 2'd3 && rb != 0 && ra / rb > 511) ra = 18'($urandom_range(0, 511) * rb);
            r = model(rop, ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, r.f, r.s, r.err, r.edges,
                  $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
